// File: rtl/uart_out_arbiter.sv
// uart_out_arbiter
//   Arbitrates NUM_SRC message sources onto a single outbound UART message
//   FIFO. A grant is made only from IDLE, only while the FIFO is not full, and
//   each write is followed by a one-cycle SETTLE. That SETTLE cycle lets the
//   FIFO's registered full flag catch up before the next grant decision.
//
// Parameters
//   MSG_WIDTH  : width of one message word (equals the FIFO data width)
//   NUM_SRC    : number of requesters (>= 2)
//   FIXED_PRIO : 0 = round-robin, 1 = fixed priority (source 0 highest)
//
// Ports
//   clk           : clock, rising edge
//   n_reset       : asynchronous active-low reset
//   src_valid     : per-source request
//   src_msg       : per-source message, source i on [i*MSG_WIDTH +: MSG_WIDTH]
//   src_ack       : one-hot accept pulse, high during WRITE only
//   uart_out_full : FIFO full flag, sampled only in IDLE
//   uart_out_msg  : FIFO write data, holds the last written word
//   uart_out_req  : FIFO write enable, high during WRITE only
//   busy          : high whenever the FSM is not in IDLE
module uart_out_arbiter #(
  parameter int MSG_WIDTH  = 32,
  parameter int NUM_SRC    = 3,
  parameter int FIXED_PRIO = 0
) (
  input  logic                         clk,
  input  logic                         n_reset,
  input  logic [NUM_SRC-1:0]           src_valid,
  input  logic [NUM_SRC*MSG_WIDTH-1:0] src_msg,
  output logic [NUM_SRC-1:0]           src_ack,
  input  logic                         uart_out_full,
  output logic [MSG_WIDTH-1:0]         uart_out_msg,
  output logic                         uart_out_req,
  output logic                         busy
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  // Reset value of last_grant: the search then starts at source 0.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SRC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t               state_reg;
  state_t               state_next;
  logic                 grant;
  logic [IDX_W-1:0]     winner;
  logic [IDX_W-1:0]     last_grant_reg;
  logic [NUM_SRC-1:0]   ack_reg;
  logic [MSG_WIDTH-1:0] msg_reg;
  logic [NUM_SRC-1:0]   above_mask;
  logic [NUM_SRC-1:0]   masked_valid;
  logic [MSG_WIDTH-1:0] msg_arr [NUM_SRC];

  // Slice the flat message bus. Also mark the sources that sit above the
  // last grant; these are searched first in round-robin mode. In fixed
  // priority mode the mask is all zero, so the search falls straight through
  // to the plain lowest-index pick.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign msg_arr[gi]    = src_msg[gi*MSG_WIDTH +: MSG_WIDTH];
      assign above_mask[gi] = (FIXED_PRIO == 0) && (IDX_W'(gi) > last_grant_reg);
    end
  endgenerate

  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_SRC-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  // Round-robin search. First pick the lowest requester above last_grant.
  // If none exists, wrap around and pick the lowest requester overall.
  assign masked_valid = src_valid & above_mask;
  assign winner       = (|masked_valid) ? lowest_set(masked_valid) : lowest_set(src_valid);

  // FSM next-state logic.
  always_comb begin
    state_next = state_reg;
    grant      = 1'b0;
    case (state_reg)
      IDLE: begin
        if ((|src_valid) && !uart_out_full) begin
          grant      = 1'b1;
          state_next = WRITE;
        end
      end
      WRITE:   state_next = SETTLE;
      SETTLE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Grant datapath. It captures the winner's message and ack vector at the
  // IDLE->WRITE edge. In fixed priority mode last_grant is still tracked,
  // but nothing reads it.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      msg_reg        <= '0;
      ack_reg        <= '0;
      last_grant_reg <= LAST_IDX;
    end else if (grant) begin
      msg_reg        <= msg_arr[winner];
      ack_reg        <= NUM_SRC'(1) << winner;
      last_grant_reg <= winner;
    end
  end

  // req and ack come straight from the state register. An asynchronous reset
  // in WRITE therefore kills both pulses at once.
  assign uart_out_req = (state_reg == WRITE);
  assign src_ack      = uart_out_req ? ack_reg : '0;
  assign uart_out_msg = msg_reg;
  assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_out_arbiter.sv
// Directed and random checks for uart_out_arbiter. One instance runs in
// round-robin mode and a second runs with fixed priority.
module tb_uart_out_arbiter;

  localparam int W = 32;
  localparam int N = 3;

  logic           clk;
  logic           n_reset;
  logic [N-1:0]   src_valid;
  logic [N-1:0]   fp_valid;
  logic [N*W-1:0] src_msg;
  logic           uart_out_full;
  logic [N-1:0]   src_ack,  fp_ack;
  logic [W-1:0]   out_msg,  fp_msg;
  logic           out_req,  fp_req;
  logic           busy,     fp_busy;

  int tests = 0;
  int fails = 0;

  uart_out_arbiter #(.MSG_WIDTH(W), .NUM_SRC(N), .FIXED_PRIO(0)) dut (
    .clk(clk), .n_reset(n_reset), .src_valid(src_valid), .src_msg(src_msg),
    .src_ack(src_ack), .uart_out_full(uart_out_full), .uart_out_msg(out_msg),
    .uart_out_req(out_req), .busy(busy)
  );

  uart_out_arbiter #(.MSG_WIDTH(W), .NUM_SRC(N), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .n_reset(n_reset), .src_valid(fp_valid), .src_msg(src_msg),
    .src_ack(fp_ack), .uart_out_full(uart_out_full), .uart_out_msg(fp_msg),
    .uart_out_req(fp_req), .busy(fp_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge. Outputs are then read 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_msg(input int s, input logic [W-1:0] v);
    src_msg[s*W +: W] = v;
  endtask

  task automatic do_reset();
    n_reset = 1'b0;
    #1;
    check("rst_req", {63'd0, out_req}, 64'd0);
    check("rst_ack", {61'd0, src_ack}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_msg", {32'd0, out_msg}, 64'd0);
    @(posedge clk);
    #3;
    n_reset = 1'b1;
  endtask

  // Random-traffic model state.
  logic [W-1:0] cur_msg [N];
  int seq_cnt   = 0;
  int gen_cnt   = 0;
  int write_cnt = 0;

  task automatic rnd_step(input bit gen);
    logic full_at_edge;
    int   s;
    uart_out_full = gen ? ($urandom_range(0, 2) == 0) : 1'b0;
    for (int i = 0; i < N; i++) begin
      if (gen && !src_valid[i] && ($urandom_range(0, 2) == 0)) begin
        seq_cnt++;
        cur_msg[i] = (W'(i) << 28) | W'(seq_cnt);
        set_msg(i, cur_msg[i]);
        src_valid[i] = 1'b1;
        gen_cnt++;
      end
    end
    full_at_edge = uart_out_full;
    tick();
    if (out_req) begin
      s = 0;
      for (int i = 0; i < N; i++) if (src_ack[i]) s = i;
      check("rnd_full_low", {63'd0, full_at_edge}, 64'd0);
      check("rnd_onehot", {63'd0, $onehot(src_ack)}, 64'd1);
      check("rnd_src_valid", {63'd0, src_valid[s]}, 64'd1);
      check("rnd_msg", {32'd0, out_msg}, {32'd0, cur_msg[s]});
      $display("[TB] rnd write src %0d msg %08h", s, out_msg);
      write_cnt++;
      // On ack the source either presents its next message or drops valid.
      if (gen && ($urandom_range(0, 1) == 0)) begin
        seq_cnt++;
        cur_msg[s] = (W'(s) << 28) | W'(seq_cnt);
        set_msg(s, cur_msg[s]);
        gen_cnt++;
      end else begin
        src_valid[s] = 1'b0;
      end
    end else begin
      check("rnd_ack_no_req", {61'd0, src_ack}, 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_reset       = 1'b0;
    src_valid     = '0;
    fp_valid      = '0;
    src_msg       = '0;
    uart_out_full = 1'b0;
    for (int i = 0; i < N; i++) cur_msg[i] = '0;

    // ---- Single source 1 ----
    do_reset();
    set_msg(1, 32'h11223344);
    src_valid = 3'b010;
    tick();
    $display("[TB] single: req=%0d ack=%b msg=%08h", out_req, src_ack, out_msg);
    check("single_req", {63'd0, out_req}, 64'd1);
    check("single_ack", {61'd0, src_ack}, 64'h2);
    check("single_msg", {32'd0, out_msg}, 64'h11223344);
    check("single_busy1", {63'd0, busy}, 64'd1);
    src_valid = 3'b000;
    tick();
    check("single_req_settle", {63'd0, out_req}, 64'd0);
    check("single_ack_settle", {61'd0, src_ack}, 64'd0);
    check("single_busy2", {63'd0, busy}, 64'd1);
    check("single_msg_hold", {32'd0, out_msg}, 64'h11223344);
    tick();
    check("single_busy_idle", {63'd0, busy}, 64'd0);
    check("single_req_idle", {63'd0, out_req}, 64'd0);

    // ---- Round-robin, all three valid ----
    do_reset();
    for (int i = 0; i < N; i++) set_msg(i, 32'hA0000000 | i);
    src_valid = 3'b111;
    for (int c = 1; c <= 18; c++) begin
      tick();
      if (c % 3 == 1) begin
        $display("[TB] rr grant: cycle %0d ack=%b msg=%08h", c, src_ack, out_msg);
        check("rr_req", {63'd0, out_req}, 64'd1);
        check("rr_ack", {61'd0, src_ack}, 64'd1 << ((c / 3) % 3));
        check("rr_msg", {32'd0, out_msg}, {32'd0, 32'hA0000000 | ((c / 3) % 3)});
      end else begin
        check("rr_gap_req", {63'd0, out_req}, 64'd0);
      end
    end
    src_valid = 3'b000;

    // ---- Fixed priority: 0 starves 2 until it drops ----
    set_msg(0, 32'hF0F00000);
    set_msg(2, 32'hF0F00002);
    fp_valid = 3'b101;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c % 3 == 1) begin
        $display("[TB] fp grant: cycle %0d ack=%b", c, fp_ack);
        check("fp_ack_src0", {61'd0, fp_ack}, 64'h1);
        check("fp_msg_src0", {32'd0, fp_msg}, 64'hF0F00000);
      end else begin
        check("fp_gap_req", {63'd0, fp_req}, 64'd0);
      end
    end
    fp_valid = 3'b100;
    tick();
    $display("[TB] fp grant after drop: ack=%b msg=%08h", fp_ack, fp_msg);
    check("fp_ack_src2", {61'd0, fp_ack}, 64'h4);
    check("fp_msg_src2", {32'd0, fp_msg}, 64'hF0F00002);
    fp_valid = 3'b000;
    tick();
    tick();

    // ---- FIFO full for 10 cycles with source 2 waiting ----
    set_msg(2, 32'h55AA33CC);
    src_valid     = 3'b100;
    uart_out_full = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("full_no_req", {63'd0, out_req}, 64'd0);
      check("full_no_ack", {61'd0, src_ack}, 64'd0);
    end
    uart_out_full = 1'b0;
    tick();
    $display("[TB] full released: req=%0d ack=%b msg=%08h", out_req, src_ack, out_msg);
    check("full_rel_req", {63'd0, out_req}, 64'd1);
    check("full_rel_ack", {61'd0, src_ack}, 64'h4);
    check("full_rel_msg", {32'd0, out_msg}, 64'h55AA33CC);
    src_valid = 3'b000;
    tick();
    tick();

    // ---- Reset during WRITE ----
    set_msg(0, 32'hC0C00000);
    set_msg(1, 32'hC0C00001);
    src_valid = 3'b010;
    tick();
    check("rw_req_before", {63'd0, out_req}, 64'd1);
    #2;
    n_reset = 1'b0;
    #1;
    $display("[TB] reset in write: req=%0d ack=%b busy=%0d", out_req, src_ack, busy);
    check("rw_req_drop", {63'd0, out_req}, 64'd0);
    check("rw_ack_drop", {61'd0, src_ack}, 64'd0);
    check("rw_busy_drop", {63'd0, busy}, 64'd0);
    check("rw_msg_clear", {32'd0, out_msg}, 64'd0);
    src_valid = 3'b011;
    #2;
    n_reset = 1'b1;
    tick();
    $display("[TB] after reset: ack=%b msg=%08h", src_ack, out_msg);
    check("rw_first_ack", {61'd0, src_ack}, 64'h1);
    check("rw_first_msg", {32'd0, out_msg}, 64'hC0C00000);
    src_valid = 3'b010;
    tick();
    tick();
    tick();
    check("rw_second_ack", {61'd0, src_ack}, 64'h2);
    src_valid = 3'b000;
    tick();
    tick();

    // ---- Random traffic ----
    for (int c = 0; c < 400; c++) rnd_step(1'b1);
    for (int c = 0; c < 40; c++) rnd_step(1'b0);
    check("rnd_drained", {61'd0, src_valid}, 64'd0);
    check("rnd_count", 64'(write_cnt), 64'(gen_cnt));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
